// File: rtl/cpu_controller_if.sv
// Decoder/datapath <-> cpu_controller signal bundle.
// The master modport is the controller; the slave modport is the decoder/datapath side.
interface cpu_controller_if;
    logic [2:0] opcode;
    logic [1:0] op;
    logic [2:0] cond;
    logic       N;
    logic       V;
    logic       Z;

    logic [2:0] nsel;
    logic [1:0] vsel;
    logic       write;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       asel;
    logic       bsel;
    logic       load_ir;
    logic       load_pc;
    logic       reset_pc;
    logic       pc_sel;
    logic       load_addr;
    logic       addr_sel;
    logic [1:0] mem_cmd;
    logic       halted;

    modport master (
        input  opcode, op, cond, N, V, Z,
        output nsel, vsel, write, loada, loadb, loadc, loads, asel, bsel,
               load_ir, load_pc, reset_pc, pc_sel, load_addr, addr_sel, mem_cmd, halted
    );

    modport slave (
        output opcode, op, cond, N, V, Z,
        input  nsel, vsel, write, loada, loadb, loadc, loads, asel, bsel,
               load_ir, load_pc, reset_pc, pc_sel, load_addr, addr_sel, mem_cmd, halted
    );
endinterface

// File: rtl/cpu_controller.sv
// Multi-cycle Moore control FSM for the RISC datapath (fetch, decode, execute).
// Optional conditional branch state enabled by defining BRANCH_EN.
module cpu_controller #(
    parameter int         STATE_W = 5,
    parameter logic [1:0] MNONE   = 2'b00,
    parameter logic [1:0] MREAD   = 2'b01,
    parameter logic [1:0] MWRITE  = 2'b10
) (
    input  logic             clk,
    input  logic             reset_n,
    cpu_controller_if.master bus
);

    typedef enum logic [STATE_W-1:0] {
        S_RESET, S_IF1, S_IF2, S_UPD, S_DEC,
        S_GA, S_GB, S_EX, S_EXZ, S_CMP, S_WR, S_WIMM,
        S_ADR, S_LA, S_MRD, S_WM, S_GD, S_PB, S_MWR,
        S_HALT
`ifdef BRANCH_EN
        , S_BR
`endif
    } state_t;

    // Instruction class remembered from DEC so later states need not re-read the decoder.
    typedef enum logic [2:0] {K_ALU, K_CMP, K_MOVZ, K_LDR, K_STR} kind_t;

    typedef struct packed {
        logic [2:0] nsel;
        logic [1:0] vsel;
        logic       write;
        logic       loada;
        logic       loadb;
        logic       loadc;
        logic       loads;
        logic       asel;
        logic       bsel;
        logic       load_ir;
        logic       load_pc;
        logic       reset_pc;
        logic       pc_sel;
        logic       load_addr;
        logic       addr_sel;
        logic [1:0] mem_cmd;
        logic       halted;
    } ctrl_t;

    state_t state_reg, state_next;
    kind_t  kind_reg, kind_next;
    ctrl_t  ctrl_reg, ctrl_next;

    function automatic ctrl_t outputs_of(state_t s);
        ctrl_t c;
        c = '0;
        c.mem_cmd = MNONE;
        case (s)
            S_RESET: begin c.reset_pc = 1'b1; c.load_pc = 1'b1; end
            S_IF1:   begin c.addr_sel = 1'b1; c.mem_cmd = MREAD; end
            S_IF2:   begin c.addr_sel = 1'b1; c.mem_cmd = MREAD; c.load_ir = 1'b1; end
            S_UPD:   c.load_pc = 1'b1;
            S_GA:    begin c.nsel = 3'b001; c.loada = 1'b1; end
            S_GB:    begin c.nsel = 3'b100; c.loadb = 1'b1; end
            S_EX:    c.loadc = 1'b1;
            S_EXZ:   begin c.loadc = 1'b1; c.asel = 1'b1; end
            S_CMP:   c.loads = 1'b1;
            S_WR:    begin c.nsel = 3'b010; c.vsel = 2'b00; c.write = 1'b1; end
            S_WIMM:  begin c.nsel = 3'b001; c.vsel = 2'b10; c.write = 1'b1; end
            S_ADR:   begin c.bsel = 1'b1; c.loadc = 1'b1; end
            S_LA:    c.load_addr = 1'b1;
            S_MRD:   c.mem_cmd = MREAD;
            S_WM:    begin c.nsel = 3'b010; c.vsel = 2'b11; c.write = 1'b1; c.mem_cmd = MREAD; end
            S_GD:    begin c.nsel = 3'b010; c.loadb = 1'b1; end
            S_PB:    begin c.asel = 1'b1; c.loadc = 1'b1; end
            S_MWR:   c.mem_cmd = MWRITE;
            S_HALT:  c.halted = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

`ifdef BRANCH_EN
    logic taken;
    always_comb begin
        taken = 1'b0;
        case (bus.cond)
            3'b000:  taken = 1'b1;
            3'b001:  taken = bus.Z;
            3'b010:  taken = !bus.Z;
            3'b011:  taken = bus.N ^ bus.V;
            3'b100:  taken = (bus.N ^ bus.V) | bus.Z;
            default: taken = 1'b0;
        endcase
    end
`else
    logic unused_branch_inputs;
    assign unused_branch_inputs = ^{bus.cond, bus.N, bus.V, bus.Z};
`endif

    always_comb begin
        state_next = state_reg;
        kind_next  = kind_reg;
        case (state_reg)
            S_RESET: state_next = S_IF1;
            S_IF1:   state_next = S_IF2;
            S_IF2:   state_next = S_UPD;
            S_UPD:   state_next = S_DEC;
            S_DEC: begin
                state_next = S_IF1;
                casez ({bus.opcode, bus.op})
                    5'b110_10:           state_next = S_WIMM;
                    5'b110_00, 5'b101_11: begin state_next = S_GB; kind_next = K_MOVZ; end
                    5'b101_00, 5'b101_10: begin state_next = S_GA; kind_next = K_ALU;  end
                    5'b101_01:           begin state_next = S_GA; kind_next = K_CMP;  end
                    5'b011_00:           begin state_next = S_GA; kind_next = K_LDR;  end
                    5'b100_00:           begin state_next = S_GA; kind_next = K_STR;  end
                    5'b111_??:           state_next = S_HALT;
`ifdef BRANCH_EN
                    5'b001_??:           state_next = S_BR;
`endif
                    default:             state_next = S_IF1;
                endcase
            end
            S_GA:    state_next = (kind_reg == K_LDR || kind_reg == K_STR) ? S_ADR : S_GB;
            S_GB: begin
                case (kind_reg)
                    K_CMP:   state_next = S_CMP;
                    K_MOVZ:  state_next = S_EXZ;
                    default: state_next = S_EX;
                endcase
            end
            S_EX, S_EXZ: state_next = S_WR;
            S_ADR:   state_next = S_LA;
            S_LA:    state_next = (kind_reg == K_STR) ? S_GD : S_MRD;
            S_MRD:   state_next = S_WM;
            S_GD:    state_next = S_PB;
            S_PB:    state_next = S_MWR;
            S_HALT:  state_next = S_HALT;
            default: state_next = S_IF1;
        endcase
    end

    // Outputs are registered alongside the state, so they are decoded from state_next.
    always_comb begin
        ctrl_next = outputs_of(state_next);
`ifdef BRANCH_EN
        if (state_next == S_BR) begin
            ctrl_next.load_pc = taken;
            ctrl_next.pc_sel  = taken;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= S_RESET;
            kind_reg  <= K_ALU;
            ctrl_reg  <= outputs_of(S_RESET);
        end else begin
            state_reg <= state_next;
            kind_reg  <= kind_next;
            ctrl_reg  <= ctrl_next;
        end
    end

    assign bus.nsel      = ctrl_reg.nsel;
    assign bus.vsel      = ctrl_reg.vsel;
    assign bus.write     = ctrl_reg.write;
    assign bus.loada     = ctrl_reg.loada;
    assign bus.loadb     = ctrl_reg.loadb;
    assign bus.loadc     = ctrl_reg.loadc;
    assign bus.loads     = ctrl_reg.loads;
    assign bus.asel      = ctrl_reg.asel;
    assign bus.bsel      = ctrl_reg.bsel;
    assign bus.load_ir   = ctrl_reg.load_ir;
    assign bus.load_pc   = ctrl_reg.load_pc;
    assign bus.reset_pc  = ctrl_reg.reset_pc;
    assign bus.pc_sel    = ctrl_reg.pc_sel;
    assign bus.load_addr = ctrl_reg.load_addr;
    assign bus.addr_sel  = ctrl_reg.addr_sel;
    assign bus.mem_cmd   = ctrl_reg.mem_cmd;
    assign bus.halted    = ctrl_reg.halted;

endmodule
